// File: rtl/conv_pkg.sv
// conv_pkg: shared width derivation and saturation helpers for the convolution datapath
package conv_pkg;
  typedef struct packed {
    logic [63:0] data;
    logic        sat;
  } sat_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int prod_w(input int iw);
    return 2 * iw;
  endfunction
  function automatic int sum_w(input int iw, input int n);
    return prod_w(iw) + clog2(n);
  endfunction
  function automatic int acc_w(input int iw, input int n, input int guard);
    return sum_w(iw, n) + guard;
  endfunction
  function automatic int level_count(input int n, input int k);
    return (n + (1 << k) - 1) >> k;
  endfunction
  function automatic sat_t saturate(input logic signed [127:0] v, input bit sgn, input int ow);
    logic signed [127:0] hi, lo;
    sat_t r;
    hi = sgn ? (128'sd1 <<< (ow - 1)) - 128'sd1 : (128'sd1 <<< ow) - 128'sd1;
    lo = sgn ? -(128'sd1 <<< (ow - 1)) : 128'sd0;
    r.sat  = (v > hi) || (v < lo);
    r.data = v > hi ? hi[63:0] : v < lo ? lo[63:0] : v[63:0];
    return r;
  endfunction
endpackage

// File: rtl/conv_add_level.sv
// conv_add_level: one registered adder-tree level; pairs are summed, an odd leftover passes through
module conv_add_level #(
  parameter int COUNT  = 2,
  parameter int W      = 16,
  parameter int SIGNED = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             en,
  input  logic [COUNT*W-1:0]               in_data,
  output logic [((COUNT+1)/2)*(W+1)-1:0]   out_data
);
  localparam int OC = (COUNT + 1) / 2;
  logic [OC*(W+1)-1:0] sum;
  for (genvar i = 0; i < OC; i++) begin : g_pair
    logic [W:0] x, y;
    assign x = {SIGNED != 0 && in_data[W*(2*i)+W-1], in_data[W*(2*i) +: W]};
    if (2 * i + 1 < COUNT) begin : g_two
      assign y = {SIGNED != 0 && in_data[W*(2*i+1)+W-1], in_data[W*(2*i+1) +: W]};
    end else begin : g_one
      assign y = '0;
    end
    assign sum[(W+1)*i +: W+1] = x + y;
  end
  always_ff @(posedge clock) begin
    if (reset) out_data <= '0;
    else if (en) out_data <= sum;
  end
endmodule

// File: rtl/conv_mac_tree.sv
// conv_mac_tree: pipelined N-element dot product with adder tree, group accumulation and saturation
module conv_mac_tree
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE_SQ = 9,
  parameter int IN_WIDTH       = 8,
  parameter int SIGNED         = 1,
  parameter int OUT_WIDTH      = 16,
  parameter int ACC_GUARD      = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_last,
  input  logic [KERNEL_SIZE_SQ*IN_WIDTH-1:0] in_data,
  input  logic [KERNEL_SIZE_SQ*IN_WIDTH-1:0] kernel_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [OUT_WIDTH-1:0]               out_data,
  output logic                               out_sat
);
  localparam int N  = KERNEL_SIZE_SQ;
  localparam int D  = clog2(N);
  localparam int PW = prod_w(IN_WIDTH);
  localparam int SW = sum_w(IN_WIDTH, N);
  localparam int AW = acc_w(IN_WIDTH, N, ACC_GUARD);
  logic                pipe_en;
  logic [N*PW-1:0]     prod_c, prod;
  logic [D:0]          vld, lst;
  logic [SW-1:0]       tree_sum;
  logic [AW-1:0]       tree_x, acc, acc_next;
  logic signed [127:0] acc_x;
  logic                first;
  sat_t                sr;
  assign pipe_en  = !(out_valid && !out_ready);
  assign in_ready = pipe_en;
  for (genvar i = 0; i < N; i++) begin : g_mul
    logic [IN_WIDTH-1:0] a, b;
    assign a = in_data[IN_WIDTH*i +: IN_WIDTH];
    assign b = kernel_data[IN_WIDTH*i +: IN_WIDTH];
    if (SIGNED != 0) begin : g_s
      assign prod_c[PW*i +: PW] = PW'($signed(a)) * PW'($signed(b));
    end else begin : g_u
      assign prod_c[PW*i +: PW] = PW'(a) * PW'(b);
    end
  end
  if (D == 0) begin : g_flat
    assign tree_sum = prod;
  end else begin : g_tree
    for (genvar k = 1; k <= D; k++) begin : g_lvl
      localparam int CI = level_count(N, k - 1);
      localparam int CO = level_count(N, k);
      localparam int WI = PW + k - 1;
      logic [CI*WI-1:0]     din;
      logic [CO*(WI+1)-1:0] dout;
      if (k == 1) begin : g_in
        assign din = prod;
      end else begin : g_in
        assign din = g_lvl[k-1].dout;
      end
      conv_add_level #(.COUNT(CI), .W(WI), .SIGNED(SIGNED)) u_lvl (
        .clock(clock), .reset(reset), .en(pipe_en), .in_data(din), .out_data(dout)
      );
    end
    assign tree_sum = g_lvl[D].dout;
  end
  if (SIGNED != 0) begin : g_sx
    assign tree_x = AW'($signed(tree_sum));
    assign acc_x  = 128'($signed(acc_next));
  end else begin : g_zx
    assign tree_x = AW'(tree_sum);
    assign acc_x  = 128'(acc_next);
  end
  assign acc_next = (first ? '0 : acc) + tree_x;
  assign sr       = saturate(acc_x, SIGNED != 0, OUT_WIDTH);
  // valid/last ride alongside data: index 0 is the product stage, index k the k-th tree level
  always_ff @(posedge clock) begin
    if (reset) begin
      vld       <= '0;
      lst       <= '0;
      prod      <= '0;
      acc       <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (pipe_en) begin
      vld[0] <= in_valid;
      lst[0] <= in_last;
      for (int k = 1; k <= D; k++) begin
        vld[k] <= vld[k-1];
        lst[k] <= lst[k-1];
      end
      prod <= prod_c;
      if (vld[D]) begin
        acc   <= acc_next;
        first <= lst[D];
      end
      out_valid <= vld[D] && lst[D];
      if (vld[D] && lst[D]) begin
        out_data <= OUT_WIDTH'(sr.data);
        out_sat  <= sr.sat;
      end
    end
  end
endmodule

// File: tb/tb_conv_mac_tree.sv
// tb_conv_mac_tree: table-driven and scoreboard checks of conv_mac_tree at N=9, 8-bit signed, 16-bit out
module tb_conv_mac_tree;
  typedef struct packed {
    logic [15:0] d;
    logic        s;
  } exp_t;
  typedef struct {
    logic signed [7:0]  a0, b0, ar, br;
    bit                 last;
    logic signed [15:0] d;
    bit                 s;
  } row_t;
  logic        clock = 0, reset = 1, in_valid = 0, in_last = 0, out_ready = 1;
  logic [71:0] in_data = '0, kernel_data = '0;
  logic        in_ready, out_valid, out_sat;
  logic [15:0] out_data;
  int          total = 0, bad = 0;
  exp_t        q[$];
  exp_t        e;
  longint      grp = 0;
  bit          prev_stall = 0, saw_block = 0;
  logic [15:0] prev_data = '0;
  row_t        tbl[17];

  conv_mac_tree dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_data(in_data), .kernel_data(kernel_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic exp_t model(input longint s);
    exp_t r;
    if (s > 32767) r = '{16'h7fff, 1'b1};
    else if (s < -32768) r = '{16'h8000, 1'b1};
    else r = '{s[15:0], 1'b0};
    return r;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (!in_ready) saw_block = 1;
      if (out_valid && !out_ready) begin
        if (prev_stall) check("hold_data", out_data, prev_data);
        prev_stall = 1;
        prev_data  = out_data;
      end else prev_stall = 0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", 1, 0);
        else begin
          e = q.pop_front();
          check("out_data", $signed(out_data), $signed(e.d));
          check("out_sat", out_sat, e.s);
        end
      end
    end
  end

  task automatic beat(input logic signed [7:0] a0, b0, ar, br, input bit last, input bit use_model);
    @(negedge clock);
    in_valid = 1;
    in_last  = last;
    for (int i = 0; i < 9; i++) begin
      in_data[8*i +: 8]     = i == 0 ? a0 : ar;
      kernel_data[8*i +: 8] = i == 0 ? b0 : br;
    end
    for (int w = 0; !in_ready; w++) begin
      if (w > 100) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
      @(negedge clock);
    end
    grp += a0 * b0 + 8 * ar * br;
    if (last) begin
      if (use_model) q.push_back(model(grp));
      grp = 0;
    end
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic drain();
    for (int w = 0; w < 200 && q.size() != 0; w++) @(negedge clock);
    check("drain", q.size(), 0);
  endtask

  initial begin
    int n;
    tbl[0]  = '{1, 1, 1, 1, 1, 9, 0};
    tbl[1]  = '{-128, -128, -128, -128, 1, 32767, 1};
    tbl[2]  = '{127, -128, 127, -128, 1, -32768, 1};
    tbl[3]  = '{10, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{20, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{-5, 1, 0, 0, 1, 25, 0};
    tbl[6]  = '{7, -3, 2, 3, 1, 27, 0};
    tbl[7]  = '{-128, 127, 0, 0, 0, 0, 0};
    tbl[8]  = '{-128, 127, 0, 0, 0, 0, 0};
    tbl[9]  = '{-16, 16, 0, 0, 1, -32768, 0};
    tbl[10] = '{127, 127, 0, 0, 0, 0, 0};
    tbl[11] = '{127, 127, 0, 0, 0, 0, 0};
    tbl[12] = '{127, 4, 0, 0, 0, 0, 0};
    tbl[13] = '{1, 1, 0, 0, 1, 32767, 0};
    tbl[14] = '{127, 127, 0, 0, 0, 0, 0};
    tbl[15] = '{127, 127, 0, 0, 0, 0, 0};
    tbl[16] = '{102, 5, 0, 0, 1, 32767, 1};
    repeat (3) @(negedge clock);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 0;
    // single-beat latency, counted in rising edges starting with the accepting one
    @(negedge clock);
    in_valid = 1;
    in_last  = 1;
    in_data  = {9{8'd1}};
    kernel_data = {9{8'd1}};
    q.push_back('{16'd9, 1'b0});
    @(posedge clock);
    #1 in_valid = 0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clock);
      #1 n++;
    end
    check("latency", n, 6);
    drain();
    foreach (tbl[r]) begin
      if (tbl[r].last) q.push_back('{tbl[r].d, tbl[r].s});
      beat(tbl[r].a0, tbl[r].b0, tbl[r].ar, tbl[r].br, tbl[r].last, 0);
    end
    idle();
    drain();
    saw_block = 0;
    fork
      for (int k = 1; k <= 8; k++) beat(8'(k), 1, 0, 0, 1, 1);
      begin
        repeat (5) @(posedge clock);
        #2 out_ready = 0;
        repeat (5) @(posedge clock);
        #2 out_ready = 1;
      end
    join
    idle();
    drain();
    check("in_ready_dropped", saw_block, 1);
    beat(50, 1, 0, 0, 0, 1);
    beat(50, 1, 0, 0, 0, 1);
    @(negedge clock);
    in_valid = 0;
    reset = 1;
    grp = 0;
    @(negedge clock);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    reset = 0;
    beat(4, 1, 0, 0, 1, 1);
    idle();
    drain();
    repeat (10) @(negedge clock);
    check("no_extra_out", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_mac_tree.md
# conv_mac_tree

Parametrised, fully pipelined dot-product engine for the convolution datapath. Each beat carries KERNEL_SIZE_SQ input/kernel element pairs. The block multiplies them in parallel, reduces the products through a registered binary adder tree, and accumulates successive beats until `in_last`. It emits one saturated result per accumulation group. It replaces the fixed-width unsigned multiply-adder: signedness, widths and tree depth are generic, it adds multi-channel accumulation, and it carries valid/ready flow control on both sides.

## Interface
- KERNEL_SIZE_SQ, 9: elements per beat (N), ≥1; any value, not only powers of two
- IN_WIDTH, 8: width of each input and kernel element
- SIGNED, 1: 1 = two's-complement operands and result; 0 = unsigned
- OUT_WIDTH, 16: result width after saturation
- ACC_GUARD, 4: extra accumulator bits above the single-beat sum width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_last  in  1  final beat of an accumulation group
- in_data  in  N*IN_WIDTH  element i at [IN_WIDTH*(i+1)-1 : IN_WIDTH*i]
- kernel_data  in  N*IN_WIDTH  same packing as in_data
- out_valid  out  1  result held until out_ready
- out_ready  in  1  downstream accepts
- out_data  out  OUT_WIDTH  saturated accumulated sum
- out_sat  out  1  out_data was clamped

## Operation
- Widths:
  - PROD_W = 2*IN_WIDTH
  - D = clog2(N); D = 0 when N = 1
  - SUM_W = PROD_W + D
  - ACC_W = SUM_W + ACC_GUARD
  - All internal arithmetic is exact at these widths. Sign-extend when SIGNED=1; zero-extend otherwise.
- Stage M: N registered products.
- Stages T1..TD: each level adds adjacent pairs. An odd leftover element is registered through unchanged, so every level has equal latency.
- Stage A (accumulate):
  - Internal `first` flag, reset value 1.
  - On each beat reaching A: acc = (first ? 0 : acc) + tree_sum; then first = last.
  - When the beat reaching A has last=1, the output register loads:
    - out_data = sat(acc_next)
    - out_sat = 1 if acc_next lies outside the OUT_WIDTH range
  - Beats with last=0 produce no output.
- Saturation limits:
  - SIGNED=1: [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]
  - SIGNED=0: [0, 2^OUT_WIDTH-1]
- The accumulator wraps silently only if a group exceeds 2^ACC_GUARD beats. This is out of contract.
- Valid and last travel in a shift pipeline alongside the data.

## Timing
- Latency L = D + 2 cycles, measured from the accepting edge of the last beat to out_valid high. For N=9, L=6.
- Throughput: one beat per cycle when out_ready is held high.
- Stall: pipe_en = !(out_valid && !out_ready), and in_ready = pipe_en.
  - When pipe_en=0, every stage, the accumulator, `first` and the outputs hold.
  - The stall is global; no stage squeezes out bubbles.
- out_valid/out_data/out_sat are stable while out_valid && !out_ready.
- Output handshake in a single cycle: out_valid clears after an out_ready edge unless a new result loads in the same cycle.
- in_valid=0 inserts a bubble. A bubble does not touch acc or `first`.
- A group may be a single beat (in_last=1 on every beat). Groups are separated only by last; there is no idle requirement between them.
- Reset, sampled at a rising edge, applies the following on the next cycle:
  - all pipeline valids 0
  - acc 0, first 1
  - out_valid 0, out_data 0, out_sat 0
  - in_ready 1

  In-flight beats and partial groups are discarded.

## Structure
- Shared package `conv_pkg`:
  - clog2 function
  - PROD_W/SUM_W/ACC_W derivation functions
  - saturation function (value, SIGNED, OUT_WIDTH → clamped value + flag)
- Sub-module `conv_add_level`:
  - one registered tree level, parametrised by input count and width
  - output count = ceil(count/2); odd element passes through
  - enable input = pipe_en
  - instantiated D times by a generate loop
- Multipliers, accumulator, `first` flag and output register live in the top module.

## Test plan
Parameters for all scenarios: N=9, IN_WIDTH=8, OUT_WIDTH=16, SIGNED=1.
- **Single beat:** all elements 1 and kernel 1, in_last=1 → out_data=9, out_sat=0, out_valid high exactly 6 cycles after acceptance.
- **Positive saturation:** in=-128 and kernel=-128 everywhere (sum 147456) → out_data=32767, out_sat=1.
- **Negative saturation:** in=127 and kernel=-128 (sum -146304) → out_data=-32768, out_sat=1.
- **Three-beat group:** beat sums 10, 20, -5, last on beat 3 → exactly one output, 25. No out_valid for beats 1–2; the next group starts from 0.
- **Backpressure:** stream 8 single-beat vectors (sums 1..8) while out_ready=0 for 5 cycles mid-stream → in_ready drops and out_data holds. All 8 results arrive in order with no loss or duplication.
- **Mid-group reset:** reset after 2 of 3 beats of a group → out_valid=0 and in_ready=1 next cycle. A subsequent single-beat group of sum 4 outputs 4, not contaminated by the earlier partial sum.
